// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
// The default widths match the async_fifo instance this stage sits behind.
package fifo_stream_pkg;

   localparam int DATA_W        = 8;
   localparam int BURST_LEN_DEF = 16;

   typedef logic [DATA_W-1:0] data_t;

   // A counter must be at least one bit wide, even when it only ever holds zero.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer. Entry 0 always holds the oldest word.
// This keeps the output data taken straight from a flop.
module fifo_skid_buf
   import fifo_stream_pkg::*;
#(
   parameter int DW = DATA_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] push_data,
   output logic [DW-1:0] head,
   output logic [1:0]    occ
);

   logic [DW-1:0] ent0_q, ent0_d;
   logic [DW-1:0] ent1_q, ent1_d;
   logic [1:0]    occ_q, occ_d;

   // The caller never pops when empty or pushes when full.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) ent0_d = push_data;
            else               ent1_d = push_data;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               ent0_d = push_data;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end

   assign head = ent0_q;
   assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Pops a first-word-fall-through FIFO into a valid/ready stream through a skid buffer.
// It frames the stream into fixed bursts and counts delivered words.
module fifo_rd_stream_adapter
   import fifo_stream_pkg::*;
#(
   parameter int DSIZE     = DATA_W,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CNT_W     = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   input  logic             enable,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int             BCW       = clog2_min1(BURST_LEN);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

   logic [1:0]       occ;
   logic             accept;
   logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

   // Popping looks only at registered occupancy, so m_ready never reaches rinc.
   assign rinc    = rrst_n & ~rempty & enable & (occ < 2'd2);
   assign m_valid = (occ != 2'd0);
   assign accept  = m_valid & m_ready;
   assign m_last  = m_valid & (beat_cnt_q == LAST_BEAT);

   fifo_skid_buf #(
      .DW (DSIZE)
   ) u_skid (
      .clk       (rclk),
      .rst_n     (rrst_n),
      .push      (rinc),
      .pop       (accept),
      .push_data (rdata),
      .head      (m_data),
      .occ       (occ)
   );

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (accept) begin
         beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
      end
      word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, accept};
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         beat_cnt_q <= '0;
         word_cnt_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: a queue-based FIFO and stream model, compared every cycle.
// A second instance with a narrow word counter checks that the counter wraps.
module tb_fifo_rd_stream_adapter;

   localparam int BURST_LEN = 16;

   logic        rclk = 1'b0;
   logic        rrst_n;
   logic [7:0]  rdata;
   logic        rempty;
   logic        enable;
   logic        m_ready;
   logic        rinc, m_valid, m_last;
   logic [7:0]  m_data;
   logic [15:0] word_cnt;
   logic        rinc_4, m_valid_4, m_last_4;
   logic [7:0]  m_data_4;
   logic [3:0]  word_cnt_4;

   logic [7:0]  fifo_q[$];
   logic [7:0]  buf_q[$];
   int          beats;
   int          cyc;
   int          checks;
   int          failures;
   int          rinc_count;
   int          last_beats[$];
   int          accept_cycles[$];
   bit          force_empty;
   logic        exp_pop, exp_acc;

   always #5 rclk = ~rclk;

   fifo_rd_stream_adapter #(.DSIZE(8), .BURST_LEN(BURST_LEN), .CNT_W(16)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
      .enable(enable), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .word_cnt(word_cnt)
   );

   fifo_rd_stream_adapter #(.DSIZE(8), .BURST_LEN(BURST_LEN), .CNT_W(4)) dut4 (
      .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc_4),
      .enable(enable), .m_data(m_data_4), .m_valid(m_valid_4), .m_ready(m_ready),
      .m_last(m_last_4), .word_cnt(word_cnt_4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_fifo();
      rempty = (fifo_q.size() == 0) || force_empty;
      rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
   endtask

   task automatic check_output();
      logic       e_valid, e_last;
      logic [7:0] e_data;
      exp_pop = rrst_n && !rempty && enable && (buf_q.size() < 2);
      e_valid = rrst_n && (buf_q.size() != 0);
      e_last  = e_valid && ((beats % BURST_LEN) == BURST_LEN - 1);
      e_data  = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
      exp_acc = e_valid && m_ready;
      chk("rinc", 32'(rinc), 32'(exp_pop));
      chk("m_valid", 32'(m_valid), 32'(e_valid));
      chk("m_last", 32'(m_last), 32'(e_last));
      chk("word_cnt", 32'(word_cnt), 32'(beats % 65536));
      chk("word_cnt_4", 32'(word_cnt_4), 32'(beats % 16));
      chk("m_valid_4", 32'(m_valid_4), 32'(e_valid));
      if (e_valid || !rrst_n) begin
         chk("m_data", 32'(m_data), 32'(e_data));
         chk("m_data_4", 32'(m_data_4), 32'(e_data));
      end
      if (m_valid && m_ready && m_last) last_beats.push_back(beats);
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic step();
      logic p, a;
      @(negedge rclk);
      check_output();
      p = exp_pop;
      a = exp_acc;
      @(posedge rclk);
      cyc++;
      if (rrst_n) begin
         if (a) begin
            void'(buf_q.pop_front());
            beats++;
            accept_cycles.push_back(cyc);
         end
         if (p) begin
            buf_q.push_back(fifo_q.pop_front());
            rinc_count++;
         end
      end
      #1;
      drive_fifo();
   endtask

   task automatic do_reset(input int base, input int n);
      rrst_n = 1'b0;
      buf_q.delete();
      beats = 0;
      fifo_q.delete();
      for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + i));
      drive_fifo();
      repeat (3) step();
      last_beats.delete();
      accept_cycles.delete();
      rrst_n = 1'b1;
   endtask

   task automatic run_to_beats(input int target, input int limit);
      int n = 0;
      while (beats < target && n < limit) begin
         step();
         n++;
      end
      if (beats < target) chk("timeout_beats", 32'(beats), 32'(target));
   endtask

   task automatic step_until_full(input int limit);
      int n = 0;
      while (buf_q.size() < 2 && n < limit) begin
         step();
         n++;
      end
      if (buf_q.size() < 2) chk("timeout_fill", 32'(buf_q.size()), 32'd2);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int rinc_snap;
      checks = 0; failures = 0; cyc = 0; beats = 0; rinc_count = 0;
      force_empty = 1'b0;
      enable = 1'b1;
      m_ready = 1'b0;
      rrst_n = 1'b1;
      fifo_q.push_back(8'hA5);
      drive_fifo();
      #2 rrst_n = 1'b0;
      #1;
      chk("t1_reset_rinc", 32'(rinc), 32'd0);
      chk("t1_reset_valid", 32'(m_valid), 32'd0);
      chk("t1_reset_wcnt", 32'(word_cnt), 32'd0);
      step();
      step();
      rrst_n = 1'b1;
      #1;
      chk("t1_first_rinc", 32'(rinc), 32'd1);
      step();
      chk("t1_first_valid", 32'(m_valid), 32'd1);
      chk("t1_first_data", 32'(m_data), 32'hA5);
      repeat (2) step();

      $display("[TB] in-order burst of 32 words");
      m_ready = 1'b1;
      enable = 1'b1;
      do_reset(0, 32);
      run_to_beats(20, 60);
      chk("t2_wcnt4_wrap", 32'(word_cnt_4), 32'd4);
      run_to_beats(32, 60);
      chk("t2_wcnt", 32'(word_cnt), 32'd32);
      chk("t2_wcnt4", 32'(word_cnt_4), 32'd0);
      chk("t2_last_count", 32'(last_beats.size()), 32'd2);
      if (last_beats.size() == 2) begin
         chk("t2_last_first", 32'(last_beats[0]), 32'd15);
         chk("t2_last_second", 32'(last_beats[1]), 32'd31);
      end
      if (accept_cycles.size() == 32)
         chk("t2_back_to_back", 32'(accept_cycles[31] - accept_cycles[0]), 32'd31);
      else
         chk("t2_accept_count", 32'(accept_cycles.size()), 32'd32);

      $display("[TB] random backpressure over 64 words");
      do_reset(0, 0);
      for (int i = 0; i < 64; i++) fifo_q.push_back(8'($urandom));
      begin
         int n = 0;
         while (beats < 64 && n < 2000) begin
            m_ready     = 1'($urandom_range(0, 1));
            force_empty = ($urandom_range(0, 7) == 0);
            enable      = ($urandom_range(0, 9) != 0);
            drive_fifo();
            step();
            n++;
         end
      end
      force_empty = 1'b0;
      enable = 1'b1;
      m_ready = 1'b1;
      drive_fifo();
      step();
      chk("t3_delivered", 32'(word_cnt), 32'd64);

      $display("[TB] enable drop mid-burst");
      m_ready = 1'b1;
      do_reset(8'h40, 32);
      run_to_beats(5, 30);
      m_ready = 1'b0;
      step_until_full(10);
      enable = 1'b0;
      m_ready = 1'b1;
      rinc_snap = rinc_count;
      repeat (6) step();
      chk("t4_drained_wcnt", 32'(word_cnt), 32'd7);
      chk("t4_no_pops", 32'(rinc_count - rinc_snap), 32'd0);
      chk("t4_empty", 32'(m_valid), 32'd0);
      enable = 1'b1;
      run_to_beats(16, 40);
      chk("t4_last_count", 32'(last_beats.size()), 32'd1);
      if (last_beats.size() != 0) chk("t4_last_beat", 32'(last_beats[0]), 32'd15);

      $display("[TB] reset mid-burst with a full buffer");
      m_ready = 1'b1;
      do_reset(8'h80, 32);
      run_to_beats(7, 30);
      m_ready = 1'b0;
      step_until_full(10);
      #1 rrst_n = 1'b0;
      buf_q.delete();
      beats = 0;
      #1;
      chk("t5_valid", 32'(m_valid), 32'd0);
      chk("t5_last", 32'(m_last), 32'd0);
      chk("t5_data", 32'(m_data), 32'd0);
      chk("t5_wcnt", 32'(word_cnt), 32'd0);
      chk("t5_rinc", 32'(rinc), 32'd0);
      step();
      step();
      rrst_n = 1'b1;
      m_ready = 1'b1;
      step();
      chk("t5_next_valid", 32'(m_valid), 32'd1);
      chk("t5_next_data", 32'(m_data), 32'h89);
      run_to_beats(1, 10);
      chk("t5_wcnt_restart", 32'(word_cnt), 32'd1);
      run_to_beats(16, 40);
      chk("t5_last_beat", 32'(last_beats.size() != 0 ? last_beats[0] : -1), 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
